// File: rtl/ma_refill_arbiter.sv
// Refill arbiter: serialises fetch-side and memory-access-side cache misses
// onto one external read port and streams the returned words into the
// owning cache as a line fill. MA misses win ties because they belong to
// the older instruction in the pipeline.
module ma_refill_arbiter #(
    parameter int WIDTH      = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_if_miss,
    input  logic [WIDTH-1:0] i_if_addr,
    input  logic             i_ma_miss,
    input  logic [WIDTH-1:0] i_ma_addr,
    output logic             o_mem_req,
    output logic [WIDTH-1:0] o_mem_addr,
    input  logic             i_mem_ack,
    input  logic [WIDTH-1:0] i_mem_rdata,
    output logic             o_fill_we_if,
    output logic             o_fill_we_ma,
    output logic [WIDTH-1:0] o_fill_addr,
    output logic [WIDTH-1:0] o_fill_data,
    output logic             o_if_done,
    output logic             o_ma_done,
    output logic             o_pipe_stall
);

    localparam int BW  = $clog2(LINE_WORDS);
    localparam int OFF = BW + 2;
    localparam logic [WIDTH-1:0] LINE_MASK = {{(WIDTH-OFF){1'b1}}, {OFF{1'b0}}};
    localparam logic [BW-1:0]    LAST_BEAT = BW'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL_MA = 3'd1,
        FILL_IF = 3'd2,
        DONE_MA = 3'd3,
        DONE_IF = 3'd4
    } state_t;

    state_t           state_q;
    logic [BW-1:0]    beat_q;
    logic [WIDTH-1:0] base_q;
    logic             mem_req_q;
    logic             if_done_q;
    logic             ma_done_q;

    logic             in_fill;
    logic [WIDTH-1:0] beat_addr;

    // Arbitration, burst sequencing and registered request/done outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            base_q    <= '0;
            mem_req_q <= 1'b0;
            if_done_q <= 1'b0;
            ma_done_q <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            ma_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_ma_miss) begin
                        state_q   <= FILL_MA;
                        base_q    <= i_ma_addr & LINE_MASK;
                        beat_q    <= '0;
                        mem_req_q <= 1'b1;
                    end else if (i_if_miss) begin
                        state_q   <= FILL_IF;
                        base_q    <= i_if_addr & LINE_MASK;
                        beat_q    <= '0;
                        mem_req_q <= 1'b1;
                    end
                end
                FILL_MA, FILL_IF: begin
                    // Without an ack everything holds; memory may stall indefinitely
                    if (i_mem_ack) begin
                        beat_q <= beat_q + BW'(1);
                        if (beat_q == LAST_BEAT) begin
                            mem_req_q <= 1'b0;
                            if (state_q == FILL_MA) begin
                                state_q   <= DONE_MA;
                                ma_done_q <= 1'b1;
                            end else begin
                                state_q   <= DONE_IF;
                                if_done_q <= 1'b1;
                            end
                        end
                    end
                end
                // Miss inputs are not sampled here: the requester is still
                // dropping its request this cycle
                DONE_MA, DONE_IF: state_q <= IDLE;
                default:          state_q <= IDLE;
            endcase
        end
    end

    // Word address of the current beat and fill-port datapath, zeroed outside a fill
    always_comb begin
        in_fill      = (state_q == FILL_MA) || (state_q == FILL_IF);
        beat_addr    = base_q + (WIDTH'(beat_q) << 2);
        o_mem_addr   = in_fill ? beat_addr   : '0;
        o_fill_addr  = in_fill ? beat_addr   : '0;
        o_fill_data  = in_fill ? i_mem_rdata : '0;
        o_fill_we_ma = (state_q == FILL_MA) && i_mem_ack;
        o_fill_we_if = (state_q == FILL_IF) && i_mem_ack;
    end

    // Stall covers the miss-detect cycle in IDLE as well as the whole burst
    always_comb begin
        o_pipe_stall = in_fill || ((state_q == IDLE) && (i_if_miss || i_ma_miss));
    end

    assign o_mem_req = mem_req_q;
    assign o_if_done = if_done_q;
    assign o_ma_done = ma_done_q;

endmodule

// File: doc/ma_refill_arbiter.md
MA_REFILL_ARBITER -- requirements
Module: ma_refill_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data and address width.
REQ-002 Parameter LINE_WORDS, default 4, words per cache line; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 i_if_miss  input  1  fetch-side cache miss, level, held until o_if_done.
REQ-006 i_if_addr  input  WIDTH  fetch miss byte address.
REQ-007 i_ma_miss  input  1  memory-access-stage cache miss, level, held until o_ma_done.
REQ-008 i_ma_addr  input  WIDTH  MA miss byte address (ALU result).
REQ-009 o_mem_req  output  1  external memory read request.
REQ-010 o_mem_addr  output  WIDTH  external word address, byte granular, word aligned.
REQ-011 i_mem_ack  input  1  beat accepted; i_mem_rdata valid same cycle.
REQ-012 i_mem_rdata  input  WIDTH  returned word.
REQ-013 o_fill_we_if / o_fill_we_ma  output  1 each  line-fill write enable to fetch / MA cache.
REQ-014 o_fill_addr  output  WIDTH  fill word address; o_fill_data  output  WIDTH  fill word.
REQ-015 o_if_done / o_ma_done  output  1 each  one-cycle fill-complete pulse.
REQ-016 o_pipe_stall  output  1  global stall to all pipeline registers.

Function
REQ-017 FSM states SHALL be IDLE, FILL_MA, FILL_IF, DONE_MA, DONE_IF.
REQ-018 IDLE: i_ma_miss -> FILL_MA; else i_if_miss -> FILL_IF; else stay.
REQ-019 Simultaneous misses SHALL grant MA first (older instruction); IF served after DONE_MA if still pending.
REQ-020 On grant, line base SHALL latch as addr with low log2(LINE_WORDS)+2 bits zeroed; beat counter cleared.
REQ-021 In FILL_*, o_mem_req SHALL be 1 and o_mem_addr = base + 4*beat; requester address changes are ignored.
REQ-022 Each cycle with i_mem_ack=1 in FILL_*: selected o_fill_we_* = 1 same cycle, o_fill_addr = o_mem_addr, o_fill_data = i_mem_rdata; beat increments.
REQ-023 Ack on beat LINE_WORDS-1 SHALL move to DONE_*; o_mem_req low from the next cycle.
REQ-024 Cycles without ack SHALL hold state, beat, and o_mem_req (no timeout).
REQ-025 DONE_* SHALL last exactly one cycle, pulse matching o_*_done, then return to IDLE.
REQ-026 Requester SHALL drop miss in the cycle after done; arbiter does not sample miss inputs in DONE_*.
REQ-027 o_pipe_stall SHALL be combinational: 1 when state is FILL_* or (state IDLE and any miss input high); 0 in DONE_*.
REQ-028 Fill enables SHALL never be high outside FILL_*, and never both high.
REQ-029 o_mem_addr, o_fill_addr, o_fill_data SHALL be 0 when not in FILL_*.
REQ-030 Beat counter width log2(LINE_WORDS); address arithmetic modulo 2^WIDTH.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, beat=0, base=0; all outputs 0 except o_pipe_stall per REQ-027.
REQ-032 rst mid-burst SHALL abort the fill: no done pulse, o_mem_req low next cycle, partial line not reported.

Verification
REQ-033 MA miss addr 0x0000_1234, ack every cycle -> o_mem_addr 0x1230,0x1234,0x1238,0x123C; 4 o_fill_we_ma pulses; o_ma_done on cycle 6 after miss; stall high cycles 1-5.
REQ-034 IF and MA miss same cycle (IF 0x40, MA 0x80) -> MA fill 0x80..0x8C, DONE_MA, then IF fill 0x40..0x4C, DONE_IF; no overlap.
REQ-035 MA miss, ack gapped 1-0-0-1-1-0-1 -> exactly 4 fills, addresses increment only on ack, req held through gaps.
REQ-036 rst asserted after 2nd beat -> req low next cycle, no o_ma_done, IDLE; new miss restarts at beat 0.
REQ-037 LINE_WORDS=8, IF miss 0xFFFF_FFFC -> base 0xFFFF_FFE0, last beat 0xFFFF_FFFC, o_if_done once.
REQ-038 Idle, no misses, random ack/rdata -> all outputs 0, no fill enable.
